// File: rtl/expr_sig_pkg.sv
// Shared definitions for the expression-block response compactor.
//   CRC32_POLY : CRC-32 generator polynomial used by the MISR (shift-left form)
//   state_t    : compactor FSM states
//   fold90to32 : XOR-fold of a 90-bit result bus down to one 32-bit MISR input word
package expr_sig_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero-extend to 96 bits so that the top word holds y[89:64] with six zero bits above it.
    function automatic logic [31:0] fold90to32(input logic [89:0] y);
        logic [95:0] y_ext;
        y_ext = {6'b0, y};
        return y_ext[31:0] ^ y_ext[63:32] ^ y_ext[95:64];
    endfunction

endpackage

// File: rtl/expr_misr32.sv
// Combinational single step of a 32-bit CRC-32 MISR (shift left, Galois feedback).
// Shared with the matching upstream LFSR stimulus block.
// Ports:
//   sig_i  in  32  current signature
//   fold_i in  32  folded sample word to absorb
//   sig_o  out 32  next signature
module expr_misr32
    import expr_sig_pkg::*;
(
    input  logic [31:0] sig_i,
    input  logic [31:0] fold_i,
    output logic [31:0] sig_o
);

    assign sig_o = {sig_i[30:0], 1'b0} ^ (sig_i[31] ? CRC32_POLY : 32'h0) ^ fold_i;

endmodule

// File: rtl/expr_sig_compactor.sv
// Response compactor for the expression_NNNNN blocks: captures one 90-bit result sample per
// accepted handshake, folds it to 32 bits, accumulates it in a CRC-32 MISR for a programmed
// number of vectors and compares the final signature against a golden value.
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high
//   start      in   1       begin a run (honoured in IDLE or DONE only)
//   abort      in   1       end the run, return to IDLE (signature/vec_count held)
//   num_vec    in   CNT_W   vectors per run, sampled on start (0 means 1)
//   golden     in   SIG_W   expected signature, sampled on start
//   y_valid    in   1       sample on y_in is valid
//   y_in       in   DATA_W  result bus from the expression block
//   y_ready    out  1       sample accepted this cycle if y_valid (RUN only)
//   busy       out  1       run in progress
//   done       out  1       run complete, held until start/abort/reset
//   pass       out  1       signature matched golden (valid while done)
//   signature  out  SIG_W   current MISR value
//   vec_count  out  CNT_W   samples accepted in current or last run
module expr_sig_compactor
    import expr_sig_pkg::*;
#(
    parameter int          DATA_W = 90,
    parameter int          SIG_W  = 32,
    parameter int          CNT_W  = 16,
    parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [SIG_W-1:0]  golden,
    input  logic              y_valid,
    input  logic [DATA_W-1:0] y_in,
    output logic              y_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_count
);

    state_t             state_q;
    logic [SIG_W-1:0]   sig_q;
    logic [SIG_W-1:0]   golden_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   limit_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    logic [31:0]        fold_w;
    logic [SIG_W-1:0]   sig_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               accept;

    assign fold_w = fold90to32(y_in);

    expr_misr32 u_misr (
        .sig_i  (sig_q),
        .fold_i (fold_w),
        .sig_o  (sig_d)
    );

    assign cnt_d  = cnt_q + CNT_W'(1);
    // ready_q is high exactly in RUN, so this is the handshake.
    assign accept = y_valid & ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sig_q    <= '0;
            golden_q <= '0;
            cnt_q    <= '0;
            limit_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else if (abort) begin
            // Any pending sample is dropped; signature and count stay for inspection.
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= RUN;
                        sig_q    <= SEED;
                        cnt_q    <= '0;
                        limit_q  <= (num_vec == '0) ? CNT_W'(1) : num_vec;
                        golden_q <= golden;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here; the run continues.
                    if (accept) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == limit_q) begin
                            // Final sample folds in on this edge; pass uses the folded value.
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_d == golden_q);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign y_ready   = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_expr_sig_compactor.sv
module tb_expr_sig_compactor;

    localparam logic [31:0] TB_SEED = 32'h0;

    logic        clk = 1'b0;
    logic        reset, start, abort, y_valid;
    logic [15:0] num_vec;
    logic [31:0] golden;
    logic [89:0] y_in;
    logic        y_ready, busy, done, pass;
    logic [31:0] signature;
    logic [15:0] vec_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] sig;
        logic [15:0] cnt;
        logic        pass;
    } exp_t;

    exp_t        sb[$];
    logic [89:0] samp [0:15];
    logic        done_prev = 1'b0;

    expr_sig_compactor #(
        .DATA_W (90),
        .SIG_W  (32),
        .CNT_W  (16),
        .SEED   (TB_SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .num_vec   (num_vec),
        .golden    (golden),
        .y_valid   (y_valid),
        .y_in      (y_in),
        .y_ready   (y_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference MISR step: fold to 32 bits, then shift-left CRC-32 with feedback.
    function automatic logic [31:0] mdl_step(input logic [31:0] s, input logic [89:0] y);
        logic [31:0] f;
        logic [31:0] n;
        f = 32'h0;
        for (int i = 0; i < 32; i++) begin
            f[i] = y[i] ^ y[i+32] ^ ((i < 26) ? y[i+64] : 1'b0);
        end
        n = s << 1;
        if (s[31]) n = n ^ 32'h04C11DB7;
        return n ^ f;
    endfunction

    // Scoreboard: every rising edge of done pops one expected run result.
    always @(negedge clk) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sig",  64'(signature), 64'(e.sig));
                check("sb_cnt",  64'(vec_count), 64'(e.cnt));
                check("sb_pass", 64'(pass),      64'(e.pass));
            end
        end
        done_prev = done;
    end

    // All tasks are entered and left just after a falling edge.
    task automatic start_run(input logic [15:0] nv, input logic [31:0] gold);
        start   = 1'b1;
        num_vec = nv;
        golden  = gold;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send(input logic [89:0] v);
        for (int w = 0; w < 20 && y_ready !== 1'b1; w++) @(negedge clk);
        check("ready_wait", 64'(y_ready), 64'h1);
        y_valid = 1'b1;
        y_in    = v;
        @(negedge clk);
        y_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(y_ready),   64'h0);
        check({tag, "_busy"},  64'(busy),      64'h0);
        check({tag, "_done"},  64'(done),      64'h0);
        check({tag, "_pass"},  64'(pass),      64'h0);
        check({tag, "_sig"},   64'(signature), 64'h0);
        check({tag, "_cnt"},   64'(vec_count), 64'h0);
    endtask

    // Full run over samp[0..n-1]; expected result pushed before stimulus starts.
    task automatic run(input logic [15:0] nv, input logic [31:0] gold, input int gap,
                       input bit poke_start);
        int          n;
        logic [31:0] s;
        exp_t        e;
        n = (nv == 16'd0) ? 1 : int'(nv);
        s = TB_SEED;
        for (int i = 0; i < n; i++) s = mdl_step(s, samp[i]);
        e.sig  = s;
        e.cnt  = 16'(n);
        e.pass = (s == gold);
        sb.push_back(e);
        start_run(nv, gold);
        for (int i = 0; i < n; i++) begin
            send(samp[i]);
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (poke_start && i == 1 && g == 0) begin
                        start   = 1'b1;
                        num_vec = 16'd9;
                        golden  = 32'hDEADBEEF;
                    end
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [95:0] r;
        logic [31:0] s;

        reset = 1'b1; start = 1'b0; abort = 1'b0; y_valid = 1'b0;
        num_vec = '0; golden = '0; y_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(y_ready), 64'h0);

        // Single zero sample
        samp[0] = 90'd0;
        run(16'd1, 32'h0, 0, 1'b0);
        check("t1_done",  64'(done),      64'h1);
        check("t1_busy",  64'(busy),      64'h0);
        check("t1_ready", 64'(y_ready),   64'h0);
        check("t1_sig",   64'(signature), 64'h0);
        check("t1_pass",  64'(pass),      64'h1);

        // Fold positions
        samp[0] = 90'd1;
        run(16'd1, 32'h1, 0, 1'b0);
        check("t2a_sig", 64'(signature), 64'h1);
        samp[0] = 90'd1 << 32;
        run(16'd1, 32'h5, 0, 1'b0);
        check("t2b_sig",  64'(signature), 64'h1);
        check("t2b_pass", 64'(pass),      64'h0);
        samp[0] = 90'd1 << 89;
        run(16'd1, 32'h02000000, 0, 1'b0);
        check("t2c_sig", 64'(signature), 64'h02000000);

        // Two samples: shift then absorb
        samp[0] = 90'd1;
        samp[1] = 90'd0;
        run(16'd2, 32'h2, 0, 1'b0);
        check("t3_sig",  64'(signature), 64'h2);
        check("t3_cnt",  64'(vec_count), 64'h2);
        check("t3_done", 64'(done),      64'h1);

        // Random samples, y_valid every other cycle, start pulsed mid-run
        for (int i = 0; i < 16; i++) begin
            r = {$urandom, $urandom, $urandom};
            samp[i] = r[89:0];
        end
        run(16'd4, 32'h0, 1, 1'b1);
        check("t4_cnt", 64'(vec_count), 64'h4);
        @(negedge clk);
        check("t4_hold", 64'(vec_count), 64'h4);

        // Back-to-back with y_valid held high, include a matching golden
        s = TB_SEED;
        for (int i = 0; i < 6; i++) s = mdl_step(s, samp[i]);
        run(16'd6, s, 0, 1'b0);
        check("t4b_pass", 64'(pass), 64'h1);

        // Abort on the 3rd accept
        start_run(16'd5, 32'h0);
        send(samp[0]);
        send(samp[1]);
        y_valid = 1'b1;
        y_in    = samp[2];
        abort   = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        y_valid = 1'b0;
        s = mdl_step(mdl_step(TB_SEED, samp[0]), samp[1]);
        check("t5_cnt",   64'(vec_count), 64'h2);
        check("t5_done",  64'(done),      64'h0);
        check("t5_busy",  64'(busy),      64'h0);
        check("t5_ready", 64'(y_ready),   64'h0);
        check("t5_sig",   64'(signature), 64'(s));
        @(negedge clk);
        start_run(16'd1, 32'h0);
        check("t5_reseed", 64'(signature), 64'(TB_SEED));
        check("t5_cnt0",   64'(vec_count), 64'h0);
        check("t5_busy1",  64'(busy),      64'h1);
        begin
            exp_t e;
            e.sig  = mdl_step(TB_SEED, samp[7]);
            e.cnt  = 16'd1;
            e.pass = (e.sig == 32'h0);
            sb.push_back(e);
        end
        send(samp[7]);

        // num_vec = 0 behaves as 1
        samp[0] = samp[9];
        run(16'd0, 32'h0, 0, 1'b0);
        check("t6_cnt", 64'(vec_count), 64'h1);

        // Reset mid-run
        start_run(16'd3, 32'h0);
        send(samp[3] | 90'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
